reg_file_rename: RTL and testbench
==================================

// Module: reg_file_rename
// PURPOSE
//  Architectural register file with per-register rename tags, for the Tomasulo core.
//  - Upstream of the reorder buffer (ROB) at issue: supplies each operand as a value or as the
//    ROB tag that will produce it, and records the ROB tag allocated for rd.
//  - Downstream of the ROB at commit: takes retired results, releases the rename when the tag matches.
//  - Clears all renames on a misprediction flush.
// PARAMETERS
//  ROB_LOG   4   ROB index width; tags are ROB_LOG bits (ROB_SIZE = 2**ROB_LOG = 16)
//  REG_NUM   32  architectural registers; index width 5; x0 hardwired to zero
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous, active-low reset (asserted when 0)
//  rdy            in   1        global enable; 0 = hold all state
//  issue_en       in   1        instruction issuing this cycle
//  issue_rs1      in   5        source register 1 index
//  issue_rs2      in   5        source register 2 index
//  issue_rd       in   5        destination register index (0 = no rename)
//  issue_rob_id   in   ROB_LOG  ROB entry allocated to the issuing instruction
//  rs1_busy       out  1        1 = rs1 pending; consumer waits on rs1_tag
//  rs1_val        out  32       rs1 value (valid when rs1_busy = 0)
//  rs1_tag        out  ROB_LOG  producer ROB tag for rs1 (valid when rs1_busy = 1)
//  rs2_busy       out  1        as rs1_busy, for rs2
//  rs2_val        out  32       as rs1_val, for rs2
//  rs2_tag        out  ROB_LOG  as rs1_tag, for rs2
//  commit_en      in   1        ROB retiring an instruction that writes rd
//  commit_rd      in   5        retired destination register
//  commit_val     in   32       retired value
//  commit_rob_id  in   ROB_LOG  ROB entry being retired
//  flush          in   1        misprediction: discard all renames
// BEHAVIOUR
//  - State: val[REG_NUM] (32b), busy[REG_NUM] (1b), tag[REG_NUM] (ROB_LOG b).
//  - Reset (rst = 0, asynchronous): all val/busy/tag = 0.
//    Therefore every output reads 0 during reset.
//  - rdy = 0: no state changes; read outputs stay combinational.
//  - Reads are combinational from issue_rs1/issue_rs2, with zero latency:
//    - busy = busy[rs]; val = val[rs]; tag = tag[rs].
//    - rs = 0 always gives busy = 0, val = 0, tag = 0.
//    - A same-cycle issue_rd == rs does NOT affect the read; the old mapping is returned.
//      Example: addi x1,x1,1 sees the previous producer of x1.
//  - Commit (posedge, rdy = 1, commit_en = 1, commit_rd != 0):
//    - val[commit_rd] <= commit_val, unconditionally.
//    - busy[commit_rd] <= 0 only if busy = 1, tag[commit_rd] == commit_rob_id,
//      and not (issue_en && issue_rd == commit_rd).
//    - A stale tag means a younger producer owns the register; the rename is kept.
//  - Issue (posedge, rdy = 1, issue_en = 1, issue_rd != 0, flush = 0):
//    - busy[issue_rd] <= 1; tag[issue_rd] <= issue_rob_id.
//    - Issue wins over a same-cycle commit release on the same register.
//  - Flush (posedge, rdy = 1, flush = 1):
//    - All busy <= 0; issue is ignored that cycle.
//    - A same-cycle commit still writes val (e.g. the mispredicted jal's rd).
//  - Writes to x0 from issue or commit are dropped; val[0] is never written.
//  - Tag wrap-around: tags are ROB indices compared by equality only. The ROB guarantees
//    no two in-flight entries share an id.
// CONFIGURATION
//  COMMIT_BYPASS_EN defined:
//    - A read of rs whose rename matches the same-cycle commit returns busy = 0 and
//      val = commit_val.
//    - Match means commit_en = 1, commit_rd == rs != 0, busy[rs] = 1 and
//      tag[rs] == commit_rob_id.
//  COMMIT_BYPASS_EN undefined:
//    - Reads see registered state only; busy = 1 and the tag are returned.
//    - The consumer must catch the value from the ROB or CDB itself.
// TESTING
//  1 Reset: rst = 0 mid-run with x5 busy -> asynchronously all outputs 0; x5 reads busy = 0, val = 0.
//  2 Rename/commit: issue rd=3 rob=7, then commit rd=3 rob=7 val=0x1234
//    -> next read of x3: busy = 0, val = 0x1234.
//  3 Stale commit: issue rd=3 rob=7, issue rd=3 rob=9, commit rd=3 rob=7 val=0xAA
//    -> x3 busy = 1, tag = 9, val = 0xAA.
//  4 Same cycle: commit rd=4 rob=2 together with issue rd=4 rob=5 rs1=4
//    -> rs1 returns the old mapping (tag 2); afterwards x4 busy = 1, tag = 5.
//  5 Flush: x1, x2, x3 busy; flush = 1 with issue rd=6 and commit rd=1 val=0x8
//    -> all busy = 0, x6 not renamed, x1 val = 0x8.
//  6 x0 / bypass: issue rd=0 -> x0 busy = 0.
//    With COMMIT_BYPASS_EN: rs1=3 busy tag 7 and same-cycle commit rob=7 val=0x55
//    -> rs1_busy = 0, rs1_val = 0x55.

Source files
------------

// File: rtl/reg_file_rename.sv
// -----------------------------------------------------------------------------
// reg_file_rename
//   Architectural register file with per-register rename tags for the Tomasulo
//   core. At issue it supplies each source operand either as a value or as the
//   ROB tag of its pending producer, and records the ROB tag allocated for rd.
//   At commit it writes the retired value and releases the rename when the
//   retiring tag is still the register's current producer. A misprediction
//   flush drops every rename.
//
// Optional feature macro: COMMIT_BYPASS_EN
//   When defined, a source read whose rename is being released by the
//   same-cycle commit returns busy = 0 and the committing value.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   rdy                 global enable; 0 holds all state
//   issue_*             issuing instruction: rs1/rs2 read, rd rename to rob_id
//   rs1_*/rs2_*         operand read results (busy, value, producer tag)
//   commit_*            retiring instruction: rd, value, rob_id
//   flush               misprediction: clear all busy bits
//
// Interface semantics: issue_en, commit_en and flush are single-cycle
// qualifiers sampled on the rising edge only while rdy = 1. There is no
// backpressure; rdy is the only stall and it freezes every register.
// -----------------------------------------------------------------------------
module reg_file_rename #(
   parameter int ROB_LOG = 4,
   parameter int REG_NUM = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               issue_en,
   input  logic [4:0]         issue_rs1,
   input  logic [4:0]         issue_rs2,
   input  logic [4:0]         issue_rd,
   input  logic [ROB_LOG-1:0] issue_rob_id,
   output logic               rs1_busy,
   output logic [31:0]        rs1_val,
   output logic [ROB_LOG-1:0] rs1_tag,
   output logic               rs2_busy,
   output logic [31:0]        rs2_val,
   output logic [ROB_LOG-1:0] rs2_tag,
   input  logic               commit_en,
   input  logic [4:0]         commit_rd,
   input  logic [31:0]        commit_val,
   input  logic [ROB_LOG-1:0] commit_rob_id,
   input  logic               flush
);

   logic [31:0]        val_q  [REG_NUM];
   logic [ROB_LOG-1:0] tag_q  [REG_NUM];
   logic [REG_NUM-1:0] busy_q;

   // The rename is released only when the retiring entry is still the
   // register's current producer and no younger producer is being installed
   // in the same cycle.
   logic commit_wr;
   logic commit_release;
   logic issue_wr;

   always_comb begin
      commit_wr      = commit_en && (commit_rd != 5'd0);
      commit_release = commit_wr && busy_q[commit_rd]
                       && (tag_q[commit_rd] == commit_rob_id)
                       && !(issue_en && (issue_rd == commit_rd));
      issue_wr       = issue_en && (issue_rd != 5'd0) && !flush;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
      end else if (rdy) begin
         // Value write is unconditional, even on flush or a stale tag.
         if (commit_wr) begin
            val_q[commit_rd] <= commit_val;
         end
         if (commit_release) begin
            busy_q[commit_rd] <= 1'b0;
         end
         // Flush and issue come last so they override a commit release.
         if (flush) begin
            busy_q <= '0;
         end else if (issue_wr) begin
            busy_q[issue_rd] <= 1'b1;
            tag_q[issue_rd]  <= issue_rob_id;
         end
      end
   end

   // Reads see the mapping before this cycle's issue; x0 is forced to zero.
   always_comb begin
      rs1_busy = 1'b0;
      rs1_val  = '0;
      rs1_tag  = '0;
      if (issue_rs1 != 5'd0) begin
         rs1_busy = busy_q[issue_rs1];
         rs1_val  = val_q[issue_rs1];
         rs1_tag  = tag_q[issue_rs1];
`ifdef COMMIT_BYPASS_EN
         if (commit_en && (commit_rd == issue_rs1) && busy_q[issue_rs1]
             && (tag_q[issue_rs1] == commit_rob_id)) begin
            rs1_busy = 1'b0;
            rs1_val  = commit_val;
         end
`endif
      end
   end

   always_comb begin
      rs2_busy = 1'b0;
      rs2_val  = '0;
      rs2_tag  = '0;
      if (issue_rs2 != 5'd0) begin
         rs2_busy = busy_q[issue_rs2];
         rs2_val  = val_q[issue_rs2];
         rs2_tag  = tag_q[issue_rs2];
`ifdef COMMIT_BYPASS_EN
         if (commit_en && (commit_rd == issue_rs2) && busy_q[issue_rs2]
             && (tag_q[issue_rs2] == commit_rob_id)) begin
            rs2_busy = 1'b0;
            rs2_val  = commit_val;
         end
`endif
      end
   end

endmodule

// File: tb/tb_reg_file_rename.sv
// -----------------------------------------------------------------------------
// tb_reg_file_rename
//   Self-checking bench for reg_file_rename: directed scenarios with literal
//   expectations, then randomized issue/commit/flush traffic checked every
//   cycle against a register-level model, then an asynchronous mid-run reset.
// -----------------------------------------------------------------------------
module tb_reg_file_rename;

   localparam int ROB_LOG = 4;
   localparam int REG_NUM = 32;

   logic               clk;
   logic               rst;
   logic               rdy;
   logic               issue_en;
   logic [4:0]         issue_rs1;
   logic [4:0]         issue_rs2;
   logic [4:0]         issue_rd;
   logic [ROB_LOG-1:0] issue_rob_id;
   logic               rs1_busy;
   logic [31:0]        rs1_val;
   logic [ROB_LOG-1:0] rs1_tag;
   logic               rs2_busy;
   logic [31:0]        rs2_val;
   logic [ROB_LOG-1:0] rs2_tag;
   logic               commit_en;
   logic [4:0]         commit_rd;
   logic [31:0]        commit_val;
   logic [ROB_LOG-1:0] commit_rob_id;
   logic               flush;

   int n_vec = 0;
   int n_err = 0;

   reg_file_rename #(.ROB_LOG(ROB_LOG), .REG_NUM(REG_NUM)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue_en(issue_en), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
      .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
      .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
      .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
      .commit_rob_id(commit_rob_id), .flush(flush)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Architectural view: a value, a pending flag and a producer id per register.
   logic [31:0]        m_val  [REG_NUM];
   logic               m_busy [REG_NUM];
   logic [ROB_LOG-1:0] m_tag  [REG_NUM];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
         end
      end else if (rdy) begin
         bit release_it;
         release_it = 0;
         if (commit_en && commit_rd != 0) begin
            m_val[commit_rd] = commit_val;
            release_it = m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id
                         && !(issue_en && issue_rd == commit_rd);
            if (release_it) m_busy[commit_rd] = 0;
         end
         if (flush) begin
            for (int i = 0; i < REG_NUM; i++) m_busy[i] = 0;
         end else if (issue_en && issue_rd != 0) begin
            m_busy[issue_rd] = 1;
            m_tag[issue_rd]  = issue_rob_id;
         end
      end
   end

   // Expected read result for one source register.
   task automatic model_read(input logic [4:0] rs, output logic b,
                             output logic [31:0] v, output logic [ROB_LOG-1:0] t);
      b = 0; v = 0; t = 0;
      if (rs != 0) begin
         b = m_busy[rs]; v = m_val[rs]; t = m_tag[rs];
`ifdef COMMIT_BYPASS_EN
         if (commit_en && commit_rd == rs && m_busy[rs] && m_tag[rs] == commit_rob_id) begin
            b = 0; v = commit_val;
         end
`endif
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Every cycle: compare both read ports against the model (mid-low phase).
   always @(negedge clk) begin
      logic b; logic [31:0] v; logic [ROB_LOG-1:0] t;
      model_read(issue_rs1, b, v, t);
      chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, b});
      if (!b) chk("rs1_val", rs1_val, v);
      else    chk("rs1_tag", {28'd0, rs1_tag}, {28'd0, t});
      model_read(issue_rs2, b, v, t);
      chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, b});
      if (!b) chk("rs2_val", rs2_val, v);
      else    chk("rs2_tag", {28'd0, rs2_tag}, {28'd0, t});
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rdy = 1; issue_en = 0; issue_rd = 0; issue_rob_id = 0;
      commit_en = 0; commit_rd = 0; commit_val = 0; commit_rob_id = 0; flush = 0;
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [ROB_LOG-1:0] id);
      idle(); issue_en = 1; issue_rd = rd; issue_rob_id = id; tick();
   endtask

   task automatic set_commit(input logic [4:0] rd, input logic [ROB_LOG-1:0] id,
                             input logic [31:0] v);
      commit_en = 1; commit_rd = rd; commit_rob_id = id; commit_val = v;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 0; idle(); issue_rs1 = 0; issue_rs2 = 0;
      #23 rst = 1;
      tick();

      // Rename then matching commit releases the register.
      do_issue(3, 7);
      idle(); set_commit(3, 7, 32'h1234); tick();
      idle(); issue_rs1 = 3; @(negedge clk);
      chk("t2_busy", {31'd0, rs1_busy}, 32'd0);
      chk("t2_val", rs1_val, 32'h1234);

      // Stale commit keeps the younger rename.
      tick();
      do_issue(3, 7);
      do_issue(3, 9);
      idle(); set_commit(3, 7, 32'hAA); tick();
      idle(); issue_rs1 = 3; @(negedge clk);
      chk("t3_busy", {31'd0, rs1_busy}, 32'd1);
      chk("t3_tag", {28'd0, rs1_tag}, 32'd9);
      tick();
      chk("t3_val", dut.val_q[3], 32'hAA);

      // Same-cycle commit and issue on x4: read sees old mapping, issue wins.
      do_issue(4, 2);
      idle(); set_commit(4, 2, 32'h44); issue_en = 1; issue_rd = 4; issue_rob_id = 5;
      issue_rs1 = 4; @(negedge clk);
`ifdef COMMIT_BYPASS_EN
      chk("t4_byp_busy", {31'd0, rs1_busy}, 32'd0);
      chk("t4_byp_val", rs1_val, 32'h44);
`else
      chk("t4_old_busy", {31'd0, rs1_busy}, 32'd1);
      chk("t4_old_tag", {28'd0, rs1_tag}, 32'd2);
`endif
      tick();
      idle(); @(negedge clk);
      chk("t4_busy", {31'd0, rs1_busy}, 32'd1);
      chk("t4_tag", {28'd0, rs1_tag}, 32'd5);
      tick();

      // Flush clears renames, drops issue, still writes commit value.
      do_issue(1, 1);
      do_issue(2, 2);
      do_issue(3, 3);
      idle(); flush = 1; issue_en = 1; issue_rd = 6; issue_rob_id = 6;
      set_commit(1, 8, 32'h8); tick();
      idle(); issue_rs1 = 1; issue_rs2 = 2; @(negedge clk);
      chk("t5_x1_busy", {31'd0, rs1_busy}, 32'd0);
      chk("t5_x1_val", rs1_val, 32'h8);
      chk("t5_x2_busy", {31'd0, rs2_busy}, 32'd0);
      tick();
      issue_rs1 = 3; issue_rs2 = 6; @(negedge clk);
      chk("t5_x3_busy", {31'd0, rs1_busy}, 32'd0);
      chk("t5_x6_busy", {31'd0, rs2_busy}, 32'd0);
      tick();

      // x0 is never renamed.
      do_issue(0, 3);
      idle(); issue_rs1 = 0; @(negedge clk);
      chk("t6_x0_busy", {31'd0, rs1_busy}, 32'd0);
      chk("t6_x0_val", rs1_val, 32'd0);
      tick();

      // Same-cycle commit of the current producer of a read operand.
      do_issue(3, 7);
      idle(); set_commit(3, 7, 32'h55); issue_rs1 = 3; @(negedge clk);
`ifdef COMMIT_BYPASS_EN
      chk("t6_byp_busy", {31'd0, rs1_busy}, 32'd0);
      chk("t6_byp_val", rs1_val, 32'h55);
`else
      chk("t6_nobyp_busy", {31'd0, rs1_busy}, 32'd1);
      chk("t6_nobyp_tag", {28'd0, rs1_tag}, 32'd7);
`endif
      tick();

      // Randomized traffic on a small register window to force collisions.
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] crd;
         idle();
         rdy          = ($urandom_range(0, 9) != 0);
         issue_en     = $urandom_range(0, 1);
         issue_rd     = 5'($urandom_range(0, 7));
         issue_rob_id = ROB_LOG'($urandom_range(0, 15));
         issue_rs1    = 5'($urandom_range(0, 7));
         issue_rs2    = 5'($urandom_range(0, 7));
         crd          = 5'($urandom_range(0, 7));
         commit_en    = $urandom_range(0, 1);
         commit_rd    = crd;
         commit_val   = $urandom;
         commit_rob_id = ($urandom_range(0, 9) < 7) ? m_tag[crd] : ROB_LOG'($urandom_range(0, 15));
         flush        = ($urandom_range(0, 29) == 0);
         tick();
      end

      // Asynchronous reset while x5 is renamed.
      idle(); issue_rs1 = 0; issue_rs2 = 0; tick();
      do_issue(5, 4);
      idle(); set_commit(9, 0, 32'h0); commit_en = 0;
      issue_rs1 = 5; issue_rs2 = 5; @(negedge clk);
      chk("t1_pre_busy", {31'd0, rs1_busy}, 32'd1);
      chk("t1_pre_tag", {28'd0, rs1_tag}, 32'd4);
      #2 rst = 0;
      #1;
      chk("t1_busy", {31'd0, rs1_busy}, 32'd0);
      chk("t1_val", rs1_val, 32'd0);
      chk("t1_tag", {28'd0, rs1_tag}, 32'd0);
      chk("t1_rs2_busy", {31'd0, rs2_busy}, 32'd0);
      #3 rst = 1;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
